// File: rtl/mem_loader.sv
// Byte-stream host loader for the shared I/O-selector memory bus: assembles
// 32-bit words from host bytes, issues memory writes/reads and returns read words as bytes.
module mem_loader #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              selector,
  output logic [WIDTH-1:0]  data_in,
  input  logic [WIDTH-1:0]  data_out,
  output logic [ADDR_W-1:0] addr,
  output logic              wr_en,
  output logic              rd_en,
  output logic              busy
);

  typedef enum logic [2:0] {
    S_IDLE, S_RX, S_WRITE, S_READ_REQ, S_READ_CAP, S_TX
  } state_t;

  localparam logic [1:0] OP_WRITE = 2'b00;
  localparam logic [1:0] OP_READ  = 2'b01;
  localparam logic [1:0] OP_SET   = 2'b10;
  localparam logic [1:0] OP_CLR   = 2'b11;

  state_t            state, state_nx;
  logic [1:0]        cnt;
  logic [1:0]        cnt_nx;
  logic              op_set;
  logic [WIDTH-1:0]  word;
  logic [WIDTH-1:0]  rd_word;
  logic [WIDTH-1:0]  rx_word;
  logic [ADDR_W-1:0] ins_ptr, dat_ptr;
  logic [ADDR_W-1:0] tgt_ptr;
  logic              rx_fire, tx_fire;

  assign rx_fire = rx_valid && rx_ready;
  assign tx_fire = tx_valid && tx_ready;
  assign cnt_nx  = cnt + 2'd1;
  // selector is latched from the command byte, so it names the target for the whole operation
  assign tgt_ptr = selector ? dat_ptr : ins_ptr;
  assign rx_word = {rx_data, word[WIDTH-9:0]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: begin
        if (rx_fire) begin
          case (rx_data[7:6])
            OP_WRITE, OP_SET: state_nx = S_RX;
            OP_READ:          state_nx = S_READ_REQ;
            default:          state_nx = S_IDLE;
          endcase
        end
      end
      S_RX:       if (rx_fire && cnt == 2'd3) state_nx = op_set ? S_IDLE : S_WRITE;
      S_WRITE:    state_nx = S_IDLE;
      S_READ_REQ: state_nx = S_READ_CAP;
      S_READ_CAP: state_nx = S_TX;
      S_TX:       if (tx_fire && cnt == 2'd3) state_nx = S_IDLE;
      default:    state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    rx_ready = (state == S_IDLE) || (state == S_RX);
    wr_en    = (state == S_WRITE);
    rd_en    = (state == S_READ_REQ);
    tx_valid = (state == S_TX);
    busy     = (state != S_IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt      <= '0;
      op_set   <= 1'b0;
      word     <= '0;
      rd_word  <= '0;
      ins_ptr  <= '0;
      dat_ptr  <= '0;
      selector <= 1'b0;
      data_in  <= '0;
      addr     <= '0;
      tx_data  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          cnt <= '0;
          if (rx_fire) begin
            selector <= rx_data[0];
            op_set   <= rx_data[7];
            if (rx_data[7:6] == OP_CLR) begin
              if (rx_data[0]) dat_ptr <= '0;
              else            ins_ptr <= '0;
            end
            if (rx_data[7:6] == OP_READ) addr <= rx_data[0] ? dat_ptr : ins_ptr;
          end
        end
        S_RX: begin
          if (rx_fire) begin
            word[{cnt, 3'b000} +: 8] <= rx_data;
            cnt <= cnt_nx;
            if (cnt == 2'd3) begin
              if (op_set) begin
                if (selector) dat_ptr <= rx_word[ADDR_W-1:0];
                else          ins_ptr <= rx_word[ADDR_W-1:0];
              end else begin
                data_in <= rx_word;
                addr    <= tgt_ptr;
              end
            end
          end
        end
        S_WRITE, S_READ_CAP: begin
          // pointer advances after every access and wraps naturally at 2**ADDR_W
          if (selector) dat_ptr <= dat_ptr + 1'b1;
          else          ins_ptr <= ins_ptr + 1'b1;
          if (state == S_READ_CAP) begin
            rd_word <= data_out;
            tx_data <= data_out[7:0];
            cnt     <= '0;
          end
        end
        S_TX: begin
          if (tx_fire) begin
            cnt <= cnt_nx;
            if (cnt != 2'd3) tx_data <= rd_word[{cnt_nx, 3'b000} +: 8];
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_loader.sv
// Randomized bench for mem_loader: a word-level reference model (pointers and
// expected memory contents) predicts every memory strobe and every returned word.
module tb_mem_loader;
  localparam int ADDR_W = 10;
  localparam int DEPTH  = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              reset;
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic [7:0]        tx_data;
  logic              tx_valid;
  logic              tx_ready;
  logic              selector;
  logic [31:0]       data_in;
  logic [31:0]       data_out = '0;
  logic [ADDR_W-1:0] addr;
  logic              wr_en;
  logic              rd_en;
  logic              busy;

  always #5 clk = ~clk;

  mem_loader #(.WIDTH(32), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .selector(selector), .data_in(data_in), .data_out(data_out),
    .addr(addr), .wr_en(wr_en), .rd_en(rd_en), .busy(busy)
  );

  // Memories behind the selector bus, one-cycle read latency
  logic [31:0] mem_i [DEPTH];
  logic [31:0] mem_d [DEPTH];
  always @(posedge clk) begin
    if (wr_en) begin
      if (selector) mem_d[addr] <= data_in;
      else          mem_i[addr] <= data_in;
    end
    if (rd_en) data_out <= selector ? mem_d[addr] : mem_i[addr];
  end

  // Strobe monitor
  typedef struct packed {
    logic              is_wr;
    logic              sel;
    logic [ADDR_W-1:0] a;
    logic [31:0]       d;
  } strobe_t;
  strobe_t sq[$];
  int  overlap_cnt = 0;
  int  long_cnt = 0;
  logic prev_wr = 1'b0, prev_rd = 1'b0;
  always @(negedge clk) begin
    if (!reset) begin
      if (wr_en && rd_en) overlap_cnt <= overlap_cnt + 1;
      if ((wr_en && prev_wr) || (rd_en && prev_rd)) long_cnt <= long_cnt + 1;
      if (wr_en || rd_en) sq.push_back({wr_en, selector, addr, data_in});
    end
    prev_wr <= wr_en;
    prev_rd <= rd_en;
  end

  // Reference model
  logic [31:0] ref_i [DEPTH];
  logic [31:0] ref_d [DEPTH];
  int ref_ins, ref_dat;

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int t;
    repeat ($urandom_range(0, 2)) @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    t = 0;
    while (!rx_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!rx_ready) check("rx_ready_timeout", 32'(rx_ready), 32'd1);
    @(negedge clk);
    rx_valid = 1'b0;
    rx_data  = 8'($urandom);
  endtask

  task automatic recv_byte(output logic [7:0] b, input int stall);
    int t;
    int bad;
    logic [7:0] held;
    t = 0;
    bad = 0;
    while (!tx_valid && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!tx_valid) begin
      check("tx_valid_timeout", 32'(tx_valid), 32'd1);
      b = 8'h00;
    end else begin
      held = tx_data;
      tx_ready = 1'b0;
      repeat (stall) begin
        @(negedge clk);
        if (tx_data !== held || tx_valid !== 1'b1) bad++;
      end
      check("tx_hold", 32'(bad), 32'd0);
      b = tx_data;
      tx_ready = 1'b1;
      @(negedge clk);
      tx_ready = 1'b0;
    end
  endtask

  task automatic wait_strobe(output strobe_t s, output bit ok);
    int t;
    t = 0;
    while (sq.size() == 0 && t < 50) begin
      @(negedge clk);
      t++;
    end
    ok = (sq.size() != 0);
    if (ok) s = sq.pop_front();
    else begin
      s = '0;
      check("strobe_timeout", 32'd0, 32'd1);
    end
  endtask

  function automatic logic [7:0] cmd(input logic [1:0] op, input bit t);
    logic [4:0] junk;
    junk = 5'($urandom);
    return {op, junk, t};
  endfunction

  task automatic do_write(input bit t, input logic [31:0] w);
    strobe_t s;
    bit ok;
    int p;
    p = t ? ref_dat : ref_ins;
    send_byte(cmd(2'b00, t));
    check("busy_rx", 32'(busy), 32'd1);
    for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8]);
    wait_strobe(s, ok);
    if (ok) begin
      check("wr_kind", 32'(s.is_wr), 32'd1);
      check("wr_sel",  32'(s.sel), 32'(t));
      check("wr_addr", 32'(s.a), 32'(p));
      check("wr_data", s.d, w);
    end
    if (t) begin ref_d[p] = w; ref_dat = (p + 1) % DEPTH; end
    else   begin ref_i[p] = w; ref_ins = (p + 1) % DEPTH; end
  endtask

  task automatic read_start(input bit t);
    strobe_t s;
    bit ok;
    int p;
    p = t ? ref_dat : ref_ins;
    send_byte(cmd(2'b01, t));
    wait_strobe(s, ok);
    if (ok) begin
      check("rd_kind", 32'(s.is_wr), 32'd0);
      check("rd_sel",  32'(s.sel), 32'(t));
      check("rd_addr", 32'(s.a), 32'(p));
    end
  endtask

  task automatic do_read(input bit t, input int big_stall);
    logic [31:0] got;
    logic [7:0]  b;
    logic [31:0] exp;
    int p;
    p = t ? ref_dat : ref_ins;
    exp = t ? ref_d[p] : ref_i[p];
    read_start(t);
    for (int k = 0; k < 4; k++) begin
      recv_byte(b, (k == 1) ? big_stall : $urandom_range(0, 3));
      got[8*k +: 8] = b;
    end
    check("rd_word", got, exp);
    if (t) ref_dat = (p + 1) % DEPTH;
    else   ref_ins = (p + 1) % DEPTH;
  endtask

  task automatic do_setaddr(input bit t, input logic [31:0] v);
    send_byte(cmd(2'b10, t));
    for (int k = 0; k < 4; k++) send_byte(v[8*k +: 8]);
    if (t) ref_dat = int'(v[ADDR_W-1:0]);
    else   ref_ins = int'(v[ADDR_W-1:0]);
  endtask

  task automatic do_clr(input bit t);
    send_byte(cmd(2'b11, t));
    check("clr_busy", 32'(busy), 32'd0);
    if (t) ref_dat = 0;
    else   ref_ins = 0;
  endtask

  task automatic check_reset_outputs(input string pfx);
    check({pfx, "_tx_valid"}, 32'(tx_valid), 32'd0);
    check({pfx, "_tx_data"},  32'(tx_data),  32'd0);
    check({pfx, "_rx_ready"}, 32'(rx_ready), 32'd1);
    check({pfx, "_busy"},     32'(busy),     32'd0);
    check({pfx, "_wr_en"},    32'(wr_en),    32'd0);
    check({pfx, "_rd_en"},    32'(rd_en),    32'd0);
    check({pfx, "_selector"}, 32'(selector), 32'd0);
    check({pfx, "_addr"},     32'(addr),     32'd0);
    check({pfx, "_data_in"},  data_in,       32'd0);
  endtask

  task automatic pulse_reset(input string pfx);
    @(negedge clk);
    #2 reset = 1'b1;
    #1 check_reset_outputs(pfx);
    rx_valid = 1'b0;
    tx_ready = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    ref_ins = 0;
    ref_dat = 0;
    check({pfx, "_rx_ready_rel"}, 32'(rx_ready), 32'd1);
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [7:0] b;
    int r;
    for (int i = 0; i < DEPTH; i++) begin
      ref_i[i] = '0;
      ref_d[i] = '0;
    end
    ref_ins  = 0;
    ref_dat  = 0;
    reset    = 1'b1;
    rx_valid = 1'b0;
    rx_data  = '0;
    tx_ready = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("por");
    reset = 1'b0;
    @(negedge clk);
    check("por_rx_ready_rel", 32'(rx_ready), 32'd1);

    do_write(1'b0, 32'h12345678);
    do_write(1'b0, 32'hCAFEF00D);

    do_setaddr(1'b1, 32'd5);
    do_write(1'b1, 32'hDEADBEEF);
    do_setaddr(1'b1, 32'h00000005);
    do_read(1'b1, 20);
    do_read(1'b1, 0);

    do_setaddr(1'b0, 32'hABCDE7FF);
    do_write(1'b0, 32'h0BADC0DE);
    do_write(1'b0, 32'h600DF00D);
    do_setaddr(1'b0, 32'h000003FF);
    do_read(1'b0, 5);
    do_read(1'b0, 0);

    do_clr(1'b1);
    do_read(1'b1, 0);
    do_write(1'b0, 32'h11223344);
    do_setaddr(1'b0, 32'd2);
    do_read(1'b0, 0);

    // Reset with a partial word in flight
    send_byte(cmd(2'b00, 1'b1));
    send_byte(8'hAA);
    send_byte(8'hBB);
    pulse_reset("rst_rx");
    do_write(1'b1, 32'h55667788);
    do_setaddr(1'b1, 32'd0);

    // Reset with a read response partly returned
    read_start(1'b1);
    recv_byte(b, 1);
    pulse_reset("rst_tx");
    do_read(1'b1, 0);

    for (int i = 0; i < 150; i++) begin
      r = $urandom_range(0, 9);
      if (r <= 3)      do_write(1'($urandom), $urandom);
      else if (r <= 6) do_read(1'($urandom), $urandom_range(0, 4));
      else if (r <= 8) do_setaddr(1'($urandom),
                                  ($urandom_range(0, 1) != 0) ? 32'($urandom_range(DEPTH - 3, DEPTH - 1))
                                                              : $urandom);
      else             do_clr(1'($urandom));
    end

    repeat (5) @(negedge clk);
    check("strobe_overlap", 32'(overlap_cnt), 32'd0);
    check("strobe_len", 32'(long_cnt), 32'd0);
    check("stray_strobes", 32'(sq.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
